// File: rtl/linx_boot_pkg.sv
// Shared types and constants for the Linx boot sequencer.
package linx_boot_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StHold    = 3'd2,
        StRun     = 3'd3,
        StDone    = 3'd4,
        StTimeout = 3'd5
    } boot_state_e;

    typedef enum logic [1:0] {
        OpSetAddr   = 2'd0,
        OpWriteWord = 2'd1,
        OpStart     = 2'd2,
        OpAbort     = 2'd3
    } boot_op_e;

    localparam logic [31:0] BOOT_TIMEOUT_CODE = 32'hDEAD_0001;

endpackage

// File: rtl/linx_boot_wdog.sv
// Run-time watchdog: counts cycles spent in RUN and flags expiry.
// Only instantiated when LINX_BOOT_WDOG_EN is defined.
module linx_boot_wdog #(
    parameter int unsigned WDOG_CYCLES = 32'd100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam logic [31:0] LastCount = 32'(WDOG_CYCLES - 1);

    logic [31:0] count_q;

    // Counter is held at zero outside RUN so it restarts on every RUN entry.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    // Firing on the last count makes the FSM leave RUN after WDOG_CYCLES cycles.
    assign expired = run && (count_q == LastCount);

endmodule

// File: rtl/linx_boot_ctrl.sv
// Boot sequencer for the Linx core: packs 32-bit program words into 64-bit
// host writes, owns core_reset and tracks halt/exit status.
// Optional run watchdog enabled by defining LINX_BOOT_WDOG_EN.
module linx_boot_ctrl
    import linx_boot_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 262144,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned WDOG_CYCLES = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        host_wvalid,
    output logic [63:0] host_waddr,
    output logic [63:0] host_wdata,
    output logic [7:0]  host_wstrb,
    output logic        core_reset,
    input  logic        core_halted,
    input  logic [31:0] core_exit_code,
    output logic [2:0]  state,
    output logic [31:0] load_words,
    output logic [31:0] exit_code,
    output logic [1:0]  err
);

    localparam logic [31:0] MemLimit = 32'(MEM_BYTES);
    localparam logic [7:0]  HoldInit = 8'(RST_HOLD);

    boot_state_e state_q, state_d;
    boot_op_e    op;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] load_words_q, load_words_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        core_reset_q, core_reset_d;
    logic        wvalid_q, wvalid_d;
    logic [63:0] waddr_q, waddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        wdog_expired;

`ifdef LINX_BOOT_WDOG_EN
    linx_boot_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q == StRun),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    assign op        = boot_op_e'(cmd_op);
    assign cmd_ready = 1'b1;

    // Next-state, datapath and host-write decode.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_words_d = load_words_q;
        exit_code_d  = exit_code_q;
        err_d        = err_q;
        hold_cnt_d   = hold_cnt_q;
        wvalid_d     = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;

        if (cmd_valid && op == OpAbort) begin
            // ABORT overrides everything, including a concurrent halt.
            state_d = StIdle;
            err_d   = 2'b00;
        end else begin
            unique case (state_q)
                StIdle, StLoad: begin
                    if (cmd_valid) begin
                        unique case (op)
                            OpSetAddr: begin
                                ptr_d        = {cmd_data[31:2], 2'b00};
                                load_words_d = '0;
                                err_d[0]     = 1'b0;
                                state_d      = StLoad;
                            end
                            OpWriteWord: begin
                                if (ptr_q < MemLimit) begin
                                    wvalid_d = 1'b1;
                                    waddr_d  = {32'd0, ptr_q[31:3], 3'b000};
                                    if (ptr_q[2]) begin
                                        wdata_d = {cmd_data, 32'd0};
                                        wstrb_d = 8'hF0;
                                    end else begin
                                        wdata_d = {32'd0, cmd_data};
                                        wstrb_d = 8'h0F;
                                    end
                                end else begin
                                    err_d[0] = 1'b1;
                                end
                                // Pointer and count advance even for dropped writes.
                                ptr_d = ptr_q + 32'd4;
                                if (load_words_q != '1) begin
                                    load_words_d = load_words_q + 32'd1;
                                end
                            end
                            OpStart: begin
                                hold_cnt_d = HoldInit;
                                state_d    = StHold;
                            end
                            default: ;
                        endcase
                    end
                end
                StHold: begin
                    if (cmd_valid) begin
                        err_d[1] = 1'b1;
                    end
                    if (hold_cnt_q == 8'd0) begin
                        state_d = StRun;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end
                StRun: begin
                    if (cmd_valid) begin
                        err_d[1] = 1'b1;
                    end
                    if (core_halted) begin
                        exit_code_d = core_exit_code;
                        state_d     = StDone;
                    end else if (wdog_expired) begin
                        exit_code_d = BOOT_TIMEOUT_CODE;
                        state_d     = StTimeout;
                    end
                end
                StDone: begin
                    if (cmd_valid) begin
                        err_d[1] = 1'b1;
                        // Load commands re-enter IDLE (asserting reset); START stays.
                        if (op != OpStart) begin
                            state_d = StIdle;
                        end
                    end
                end
`ifdef LINX_BOOT_WDOG_EN
                StTimeout: begin
                    if (cmd_valid) begin
                        err_d[1] = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        core_reset_d = !(state_d == StRun || state_d == StDone);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            load_words_q <= '0;
            exit_code_q  <= '0;
            err_q        <= '0;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            wvalid_q     <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_words_q <= load_words_d;
            exit_code_q  <= exit_code_d;
            err_q        <= err_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_q <= core_reset_d;
            wvalid_q     <= wvalid_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    assign state       = state_q;
    assign load_words  = load_words_q;
    assign exit_code   = exit_code_q;
    assign err         = err_q;
    assign core_reset  = core_reset_q;
    assign host_wvalid = wvalid_q;
    assign host_waddr  = waddr_q;
    assign host_wdata  = wdata_q;
    assign host_wstrb  = wstrb_q;

endmodule

// File: tb/tb_linx_boot_ctrl.sv
// Self-checking bench for linx_boot_ctrl (RST_HOLD=4, WDOG_CYCLES=50).
module tb_linx_boot_ctrl;

    localparam int unsigned MemBytes = 262144;
    localparam int unsigned RstHold  = 4;
    localparam int unsigned WdogCyc  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        host_wvalid;
    logic [63:0] host_waddr;
    logic [63:0] host_wdata;
    logic [7:0]  host_wstrb;
    logic        core_reset;
    logic        core_halted;
    logic [31:0] core_exit_code;
    logic [2:0]  state;
    logic [31:0] load_words;
    logic [31:0] exit_code;
    logic [1:0]  err;

    int n_cmp  = 0;
    int n_fail = 0;

    linx_boot_ctrl #(
        .MEM_BYTES   (MemBytes),
        .RST_HOLD    (RstHold),
        .WDOG_CYCLES (WdogCyc)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .host_wvalid    (host_wvalid),
        .host_waddr     (host_waddr),
        .host_wdata     (host_wdata),
        .host_wstrb     (host_wstrb),
        .core_reset     (core_reset),
        .core_halted    (core_halted),
        .core_exit_code (core_exit_code),
        .state          (state),
        .load_words     (load_words),
        .exit_code      (exit_code),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        valid;
        logic [1:0]  op;
        logic [31:0] data;
        logic        wv;
        logic [63:0] wa;
        logic [63:0] wd;
        logic [7:0]  ws;
        logic [2:0]  st;
        logic        rs;
        logic [31:0] lw;
        logic [1:0]  er;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One command (or idle) per clock; outputs are read 1ns after the edge.
    task automatic send(input logic v, input logic [1:0] o, input logic [31:0] d);
        cmd_valid = v;
        cmd_op    = o;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        vecs[0] = '{"setaddr_100", 1, 2'd0, 32'h0000_0103, 0, 64'h0, 64'h0, 8'h0,
                    3'd1, 1, 32'd0, 2'b00};
        vecs[1] = '{"wr_lo", 1, 2'd1, 32'h1111_1111, 1, 64'h100, 64'h0000_0000_1111_1111,
                    8'h0F, 3'd1, 1, 32'd1, 2'b00};
        vecs[2] = '{"wr_hi", 1, 2'd1, 32'h2222_2222, 1, 64'h100, 64'h2222_2222_0000_0000,
                    8'hF0, 3'd1, 1, 32'd2, 2'b00};
        vecs[3] = '{"idle", 0, 2'd0, 32'h0, 0, 64'h0, 64'h0, 8'h0, 3'd1, 1, 32'd2, 2'b00};
        vecs[4] = '{"setaddr_top", 1, 2'd0, 32'h0003_FFFC, 0, 64'h0, 64'h0, 8'h0,
                    3'd1, 1, 32'd0, 2'b00};
        vecs[5] = '{"wr_last", 1, 2'd1, 32'hAAAA_5555, 1, 64'h3_FFF8, 64'hAAAA_5555_0000_0000,
                    8'hF0, 3'd1, 1, 32'd1, 2'b00};
        vecs[6] = '{"wr_oor", 1, 2'd1, 32'hBBBB_BBBB, 0, 64'h0, 64'h0, 8'h0,
                    3'd1, 1, 32'd2, 2'b01};
        vecs[7] = '{"setaddr_8", 1, 2'd0, 32'h0000_0008, 0, 64'h0, 64'h0, 8'h0,
                    3'd1, 1, 32'd0, 2'b00};
        vecs[8] = '{"wr_8", 1, 2'd1, 32'h0C0F_FEE0, 1, 64'h8, 64'h0000_0000_0C0F_FEE0,
                    8'h0F, 3'd1, 1, 32'd1, 2'b00};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_data = '0;
        core_halted = 1'b0;
        core_exit_code = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_wvalid", 64'(host_wvalid), 64'd0);
        chk("rst_waddr", host_waddr, 64'd0);
        chk("rst_wdata", host_wdata, 64'd0);
        chk("rst_wstrb", 64'(host_wstrb), 64'd0);
        chk("rst_load_words", 64'(load_words), 64'd0);
        chk("rst_exit_code", 64'(exit_code), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;

        // Load path vectors.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].valid, vecs[i].op, vecs[i].data);
            chk({vecs[i].nm, "_wvalid"}, 64'(host_wvalid), 64'(vecs[i].wv));
            if (vecs[i].wv) begin
                chk({vecs[i].nm, "_waddr"}, host_waddr, vecs[i].wa);
                chk({vecs[i].nm, "_wdata"}, host_wdata, vecs[i].wd);
                chk({vecs[i].nm, "_wstrb"}, 64'(host_wstrb), 64'(vecs[i].ws));
            end
            chk({vecs[i].nm, "_state"}, 64'(state), 64'(vecs[i].st));
            chk({vecs[i].nm, "_reset"}, 64'(core_reset), 64'(vecs[i].rs));
            chk({vecs[i].nm, "_lw"}, 64'(load_words), 64'(vecs[i].lw));
            chk({vecs[i].nm, "_err"}, 64'(err), 64'(vecs[i].er));
        end

        // START: reset held for RST_HOLD cycles after the HOLD entry edge.
        send(1, 2'd2, 32'h0);
        chk("start_state", 64'(state), 64'd2);
        chk("start_reset", 64'(core_reset), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            send(0, 2'd0, 32'h0);
            chk($sformatf("hold_reset_%0d", k), 64'(core_reset), 64'd1);
        end
        send(0, 2'd0, 32'h0);
        chk("release_reset", 64'(core_reset), 64'd0);
        chk("release_state", 64'(state), 64'd3);

        // Illegal write in RUN.
        send(1, 2'd1, 32'h1234_5678);
        chk("run_wr_wvalid", 64'(host_wvalid), 64'd0);
        chk("run_wr_err", 64'(err), 64'd2);
        chk("run_wr_state", 64'(state), 64'd3);

        // Halt capture.
        core_halted = 1'b1;
        core_exit_code = 32'd7;
        send(0, 2'd0, 32'h0);
        core_halted = 1'b0;
        core_exit_code = 32'd0;
        chk("halt_state", 64'(state), 64'd4);
        chk("halt_exit", 64'(exit_code), 64'd7);
        chk("halt_reset", 64'(core_reset), 64'd0);

        // Write in DONE returns to IDLE with reset asserted.
        send(1, 2'd1, 32'h5);
        chk("done_wr_state", 64'(state), 64'd0);
        chk("done_wr_reset", 64'(core_reset), 64'd1);
        chk("done_wr_wvalid", 64'(host_wvalid), 64'd0);
        chk("done_wr_err", 64'(err), 64'd2);

        send(1, 2'd3, 32'h0);
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_reset", 64'(core_reset), 64'd1);
        chk("abort_err", 64'(err), 64'd0);
        chk("abort_exit_kept", 64'(exit_code), 64'd7);

        // START then illegal START in HOLD with core_halted ignored.
        send(1, 2'd2, 32'h0);
        core_halted = 1'b1;
        send(1, 2'd2, 32'h0);
        core_halted = 1'b0;
        chk("hold_start_err", 64'(err), 64'd2);
        chk("hold_start_state", 64'(state), 64'd2);
        cnt = 0;
        while (state != 3'd3 && cnt < 20) begin
            send(0, 2'd0, 32'h0);
            cnt++;
        end
        chk("hold_remaining", 64'(cnt), 64'd4);

        // ABORT beats a concurrent halt.
        core_halted = 1'b1;
        core_exit_code = 32'd9;
        send(1, 2'd3, 32'h0);
        core_halted = 1'b0;
        chk("abort_halt_state", 64'(state), 64'd0);
        chk("abort_halt_exit", 64'(exit_code), 64'd7);
        chk("abort_halt_reset", 64'(core_reset), 64'd1);
        chk("abort_halt_err", 64'(err), 64'd0);

        // rst mid-load restores every register.
        send(1, 2'd0, 32'h40);
        send(1, 2'd1, 32'hFFFF_FFFF);
        chk("preload_lw", 64'(load_words), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_lw", 64'(load_words), 64'd0);
        chk("midrst_exit", 64'(exit_code), 64'd0);
        chk("midrst_wvalid", 64'(host_wvalid), 64'd0);
        chk("midrst_wdata", host_wdata, 64'd0);
        chk("midrst_reset", 64'(core_reset), 64'd1);

`ifdef LINX_BOOT_WDOG_EN
        send(1, 2'd2, 32'h0);
        cnt = 0;
        while (state != 3'd3 && cnt < 20) begin
            send(0, 2'd0, 32'h0);
            cnt++;
        end
        chk("wdog_run_entry", 64'(state), 64'd3);
        cnt = 0;
        while (state != 3'd5 && cnt < 200) begin
            send(0, 2'd0, 32'h0);
            cnt++;
        end
        chk("wdog_cycles", 64'(cnt), 64'(WdogCyc));
        chk("wdog_reset", 64'(core_reset), 64'd1);
        chk("wdog_exit", 64'(exit_code), 64'hDEAD_0001);
        send(1, 2'd1, 32'h0);
        chk("wdog_cmd_err", 64'(err), 64'd2);
        chk("wdog_cmd_state", 64'(state), 64'd5);
        send(1, 2'd3, 32'h0);
        chk("wdog_abort_state", 64'(state), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/linx_boot_ctrl.md
# linx_boot_ctrl

Boot sequencer for the in-order Linx core on the PS/PL platform. It receives load and control commands from the AXI-Lite register block and packs 32-bit program words into 64-bit `host_w*` writes to core memory. It owns the core's reset line: the core is held in reset during load, released after a drain delay, and its halt and exit status are then tracked. Placement: between the platform register block and `linx_cpu_pyc`, replacing direct register-driven `core_reset` and `host_w*`.

## Interface
Parameters:
- `MEM_BYTES`, 262144: size of each core memory. Load addresses at or above this are out of range.
- `RST_HOLD`, 16: cycles `core_reset` stays high after START before release. Range 1..255.
- `WDOG_CYCLES`, 32'd100_000_000: run-time limit. Used only with `LINX_BOOT_WDOG_EN`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command strobe.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2: 0 SET_ADDR, 1 WRITE_WORD, 2 START, 3 ABORT.
- `cmd_data`  in  32: byte address for SET_ADDR, data word for WRITE_WORD; ignored otherwise.
- `host_wvalid`  out  1: memory write pulse.
- `host_waddr`  out  64: 8-byte-aligned write address.
- `host_wdata`  out  64: write data.
- `host_wstrb`  out  8: byte enables.
- `core_reset`  out  1: hold core in reset.
- `core_halted`  in  1: core has halted.
- `core_exit_code`  in  32: core exit code.
- `state`  out  3: current FSM state.
- `load_words`  out  32: words written since the last SET_ADDR.
- `exit_code`  out  32: exit code latched on halt.
- `err`  out  2: sticky flags. Bit 0 = out-of-range write; bit 1 = command illegal in the current state.

## Operation
FSM states (package enum): IDLE=0, LOAD=1, HOLD=2, RUN=3, DONE=4, TIMEOUT=5.
- **IDLE / LOAD**
  - `core_reset=1`.
  - SET_ADDR: loads `ptr <= {cmd_data[31:2],2'b00}` (bits [1:0] forced to 0), clears `load_words` and `err[0]`, moves to LOAD.
  - WRITE_WORD: issues one host write.
    - `host_waddr = {32'd0, ptr[31:3], 3'b000}`.
    - If `ptr[2]=0`: `host_wdata = {32'd0, cmd_data}`, `host_wstrb = 8'h0F`. If `ptr[2]=1`: `host_wdata = {cmd_data, 32'd0}`, `host_wstrb = 8'hF0`.
    - Then `ptr += 4` (32-bit wrap) and `load_words += 1` (saturating at 2^32-1).
    - If `ptr >= MEM_BYTES`: no write is issued, `err[0]` is set, but `ptr` and `load_words` still advance.
  - START: `hold_cnt <= RST_HOLD`, move to HOLD.
- **HOLD**
  - `core_reset=1`. `hold_cnt` decrements each cycle.
  - When it reaches 0: move to RUN and drop `core_reset` in the same edge.
- **RUN**
  - `core_reset=0`.
  - On `core_halted=1`: latch `exit_code <= core_exit_code`, move to DONE.
- **DONE**
  - `core_reset=0`. Core state is preserved for inspection.
  - SET_ADDR or WRITE_WORD: moves to IDLE and asserts reset; the command itself is otherwise discarded and sets `err[1]`.
- **ABORT**
  - From any state: next state IDLE, `core_reset=1`.
  - Clears `err`. `exit_code` and `ptr` are kept.
- **Illegal commands** (SET_ADDR/WRITE_WORD in HOLD or RUN, START outside IDLE/LOAD): accepted, dropped, `err[1]` set.
- **cmd_ready** is 1 in every state. Exactly one command is consumed per cycle.
- **Reset values:** state IDLE, `core_reset=1`, `host_wvalid=0`, `host_waddr=0`, `host_wdata=0`, `host_wstrb=0`, `ptr=0`, `load_words=0`, `exit_code=0`, `err=0`.

## Timing
- Host write: registered. `host_wvalid` is high for exactly one cycle, the cycle after WRITE_WORD is accepted. Back-to-back WRITE_WORD gives back-to-back pulses.
- `host_wvalid` and the other `host_w*` outputs are combinationally independent of `cmd_*`.
- START accepted at edge N: `core_reset` falls at edge N+RST_HOLD+1. Any write accepted at N-1 has therefore landed at least RST_HOLD cycles before release.
- Halt: `exit_code` and the DONE state are visible one cycle after `core_halted` is sampled high.
- `core_halted` is ignored outside RUN, because the core is in reset there.
- `rst` mid-load or mid-run: all registers take their reset values on the next edge. `core_reset` is high immediately after that edge.
- ABORT concurrent with `core_halted` in RUN: ABORT wins and `exit_code` is not updated.

## Configuration
- `LINX_BOOT_WDOG_EN` defined:
  - A 32-bit run counter clears on entry to RUN and increments each RUN cycle.
  - At `WDOG_CYCLES` the FSM moves to TIMEOUT: `core_reset=1`, `exit_code=32'hDEAD_0001`.
  - TIMEOUT is left only by ABORT or `rst`. Commands other than ABORT set `err[1]`.
- Undefined: no counter and no TIMEOUT state; RUN is unbounded. The encoding 5 is unused.

## Structure
- Package `linx_boot_pkg`: `boot_state_e` (3-bit), `boot_op_e` (2-bit), constant `BOOT_TIMEOUT_CODE = 32'hDEAD_0001`.
- Sub-module `linx_boot_wdog` (run counter plus timeout compare), instantiated only under `LINX_BOOT_WDOG_EN`.

## Test plan
- SET_ADDR 0x100, WRITE_WORD 0x11111111, WRITE_WORD 0x22222222 -> two consecutive pulses:
  - addr 0x100, wstrb 0x0F, wdata 0x0000000011111111;
  - addr 0x100, wstrb 0xF0, wdata 0x2222222200000000;
  - `load_words = 2`.
- With RST_HOLD=4, START at cycle 10 -> `core_reset` high through cycle 14, low at cycle 15, `state = RUN`.
- In RUN, drive `core_halted=1` with `core_exit_code = 7` -> next cycle `state = DONE`, `exit_code = 7`, `core_reset = 0`.
- SET_ADDR `MEM_BYTES-4`, then two WRITE_WORDs -> the first write is issued; the second produces no `host_wvalid` and sets `err = 2'b01`.
- WRITE_WORD in RUN -> no write, `err[1] = 1`. Then ABORT -> `state = IDLE`, `core_reset = 1`, `err = 0`.
- With `LINX_BOOT_WDOG_EN` and `WDOG_CYCLES=50`, START with no halt -> TIMEOUT reached 50 cycles after entering RUN, `core_reset = 1`, `exit_code = 0xDEAD0001`.
